// File: rtl/quantum_counter.sv
// quantum_counter: counts retired user instructions per quantum and latches the preempted user PC
module quantum_counter #(
  parameter int unsigned QUANTUM = 20,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned PCNT_W  = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              instr_retire_i,
  input  logic              stall_i,
  input  logic              enable_so_i,
  input  logic              so_return_i,
  input  logic [PC_W-1:0]   pc_curr_i,
  output logic [CNT_W-1:0]  pc_counter_o,
  output logic              in_so_o,
  output logic [PC_W-1:0]   saved_pc_o,
  output logic              saved_valid_o,
  output logic              preempt_pulse_o,
  output logic [PCNT_W-1:0] preempt_count_o
);
  typedef enum logic [1:0] {SO, USER, SWITCH} state_e;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_so_q, in_so_d;
  logic [PC_W-1:0]   saved_pc_q, saved_pc_d;
  logic              saved_valid_q, saved_valid_d;
  logic              pulse_q, pulse_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  // next state: OS waits for so_return, user counts or accepts preemption, switch lasts one cycle
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    saved_pc_d    = saved_pc_q;
    saved_valid_d = saved_valid_q;
    pulse_d       = 1'b0;
    pcnt_d        = pcnt_q;
    case (state_q)
      SO: begin
        cnt_d = '0;
        if (so_return_i) begin
          state_d       = USER;
          saved_valid_d = 1'b0;
        end
      end
      USER: begin
        if (enable_so_i) begin
          state_d       = SWITCH;
          saved_pc_d    = pc_curr_i;
          saved_valid_d = 1'b1;
          pulse_d       = 1'b1;
          pcnt_d        = pcnt_q + 1'b1;
        end else if (instr_retire_i && !stall_i && cnt_q < CNT_W'(QUANTUM)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SWITCH: begin
        cnt_d   = '0;
        state_d = SO;
      end
      default: state_d = SO;
    endcase
    in_so_d = state_d != USER;
  end
  // state and output registers; the system boots in OS mode
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q       <= SO;
      cnt_q         <= '0;
      in_so_q       <= 1'b1;
      saved_pc_q    <= '0;
      saved_valid_q <= 1'b0;
      pulse_q       <= 1'b0;
      pcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      in_so_q       <= in_so_d;
      saved_pc_q    <= saved_pc_d;
      saved_valid_q <= saved_valid_d;
      pulse_q       <= pulse_d;
      pcnt_q        <= pcnt_d;
    end
  end
  assign pc_counter_o    = cnt_q;
  assign in_so_o         = in_so_q;
  assign saved_pc_o      = saved_pc_q;
  assign saved_valid_o   = saved_valid_q;
  assign preempt_pulse_o = pulse_q;
  assign preempt_count_o = pcnt_q;
endmodule
